// File: rtl/multi_level_counter_pkg.sv
// Shared types and helpers for the multi-channel level counter.
package multi_level_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Channel-index width; at least one bit so a single channel still has an index.
  function automatic int chan_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/multi_level_counter_if.sv
// Readout stream toward the readout network: one frozen channel count per valid/ready handshake.
interface multi_level_counter_if #(
  parameter int CH    = 4,
  parameter int WIDTH = 32
);
  import multi_level_counter_pkg::*;

  localparam int CW = chan_width(CH);

  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_chan;
  logic [WIDTH-1:0] out_data;
  logic             out_over;
  logic             out_last;

  modport master (
    output out_valid, out_chan, out_data, out_over, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_chan, out_data, out_over, out_last,
    output out_ready
  );

endinterface

// File: rtl/level_counter_ch.sv
// One event channel: programmable prescaler feeding a saturating level count with a sticky overflow flag.
module level_counter_ch #(
  parameter int WIDTH = 32,
  parameter int PRE_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             over
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             over_q, over_d;

  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    over_d  = over_q;
    if (clr) begin
      pre_d   = '0;
      count_d = '0;
      over_d  = 1'b0;
    end else if (cnt_en) begin
      if (pre_q == prescale) begin
        pre_d = '0;
        // Saturate rather than wrap; the lost event is recorded in over.
        if (&count_q) over_d = 1'b1;
        else          count_d = count_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      count_q <= '0;
      over_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      over_q  <= over_d;
    end
  end

  assign count = count_q;
  assign over  = over_q;

endmodule

// File: rtl/multi_level_counter.sv
// Measurement-window controller: counts events on CH channels, then streams the frozen counts out.
module multi_level_counter
  import multi_level_counter_pkg::*;
#(
  parameter int CH    = 4,
  parameter int WIDTH = 32,
  parameter int PRE_W = 6,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CH-1:0]    en,
  output logic             busy,
  output logic             done,
  multi_level_counter_if.master rd
);

  localparam int CW = chan_width(CH);
  localparam logic [CW-1:0] LAST_CHAN = CW'(CH - 1);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CW-1:0]    chan_q, chan_d;
  logic             done_q, done_d;
  logic             clr;

  logic [WIDTH-1:0] count_w [CH];
  logic [CH-1:0]    over_w;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      level_counter_ch #(
        .WIDTH (WIDTH),
        .PRE_W (PRE_W)
      ) u_ch (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .cnt_en   ((state_q == COUNT) && en[gi]),
        .prescale (pre_q),
        .count    (count_w[gi]),
        .over     (over_w[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      pre_q   <= '0;
      chan_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pre_q   <= pre_d;
      chan_q  <= chan_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    pre_d   = pre_q;
    chan_d  = chan_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          pre_d   = prescale;
          win_d   = win_len;
          chan_d  = '0;
          state_d = (win_len == '0) ? DRAIN : COUNT;
        end
      end
      COUNT: begin
        // Window counter is never zero here; the edge taking it to zero is the last sample.
        win_d = win_q - 1'b1;
        if (win_q == WIN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (rd.out_ready) begin
          if (chan_q == LAST_CHAN) begin
            chan_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            chan_d = chan_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    done         = done_q;
    rd.out_valid = (state_q == DRAIN);
    rd.out_chan  = chan_q;
    rd.out_last  = rd.out_valid && (chan_q == LAST_CHAN);
    rd.out_data  = rd.out_valid ? count_w[chan_q] : '0;
    rd.out_over  = rd.out_valid ? over_w[chan_q] : 1'b0;
  end

endmodule

// File: tb/tb_multi_level_counter.sv
// Directed bench for multi_level_counter: expected readout words are queued at start and checked per cycle.
module tb_multi_level_counter;

  localparam int CH    = 4;
  localparam int WIDTH = 4;
  localparam int PRE_W = 6;
  localparam int WIN_W = 16;
  localparam int MAXC  = (1 << WIDTH) - 1;

  typedef struct {
    int chan;
    int data;
    int over;
    int last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic [PRE_W-1:0] prescale;
  logic [CH-1:0]    en;
  logic             busy;
  logic             done;

  multi_level_counter_if #(.CH(CH), .WIDTH(WIDTH)) rd_if ();

  multi_level_counter #(
    .CH    (CH),
    .WIDTH (WIDTH),
    .PRE_W (PRE_W),
    .WIN_W (WIN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .win_len  (win_len),
    .prescale (prescale),
    .en       (en),
    .busy     (busy),
    .done     (done),
    .rd       (rd_if)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: events seen = win when enabled, one count per (pre+1) events, clipped at MAXC.
  task automatic push_expect(input logic [CH-1:0] mask, input int win, input int pre);
    int n;
    int incs;
    for (int i = 0; i < CH; i++) begin
      n    = mask[i] ? win : 0;
      incs = n / (pre + 1);
      sb.push_back('{i, (incs > MAXC) ? MAXC : incs, (incs > MAXC) ? 1 : 0, (i == CH - 1) ? 1 : 0});
    end
  endtask

  task automatic start_run(input int win, input int pre);
    win_len  = WIN_W'(win);
    prescale = PRE_W'(pre);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    win_len  = WIN_W'($urandom);
    prescale = PRE_W'($urandom);
  endtask

  task automatic wait_window(input int win);
    repeat (win - 1) tick();
    check("count_busy", busy, 1);
    check("count_no_valid", rd_if.out_valid, 0);
    tick();
    check("drain_valid_on_time", rd_if.out_valid, 1);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic drain(input int mode, input bit pulse_start);
    int  cyc = 0;
    int  hs = 0;
    int  need;
    bit  rdy;
    need = sb.size();
    while (sb.size() > 0 && cyc < 40) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      rd_if.out_ready = rdy;
      if (pulse_start && cyc == 1) begin
        start   = 1'b1;
        win_len = WIN_W'(2);
      end else begin
        start = 1'b0;
      end
      check("rd_valid", rd_if.out_valid, 1);
      check("rd_chan", rd_if.out_chan, sb[0].chan);
      check("rd_data", rd_if.out_data, sb[0].data);
      check("rd_over", rd_if.out_over, sb[0].over);
      check("rd_last", rd_if.out_last, sb[0].last);
      check("rd_no_early_done", done, 0);
      if (rdy) begin
        $display("handshake chan=%0d data=%0d over=%0d last=%0d",
                 rd_if.out_chan, rd_if.out_data, rd_if.out_over, rd_if.out_last);
        void'(sb.pop_front());
        hs++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("drain_handshakes", hs, need);
    sb.delete();
    check("done_pulse", done, 1);
    check("done_busy_low", busy, 0);
    check("done_valid_low", rd_if.out_valid, 0);
    rd_if.out_ready = 1'b0;
    tick();
    check("done_single", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    win_len = '0;
    prescale = '0;
    en = '0;
    rd_if.out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", rd_if.out_valid, 0);
    check("rst_chan", rd_if.out_chan, 0);
    check("rst_data", rd_if.out_data, 0);
    check("rst_over", rd_if.out_over, 0);
    check("rst_last", rd_if.out_last, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Prescaled single channel.
    en = 4'b0001;
    push_expect(en, 16, 3);
    start_run(16, 3);
    wait_window(16);
    drain(0, 1'b0);

    // Saturation with and without a lost increment.
    en = 4'b1111;
    push_expect(en, 20, 0);
    start_run(20, 0);
    wait_window(20);
    drain(0, 1'b0);
    push_expect(en, 15, 0);
    start_run(15, 0);
    wait_window(15);
    drain(0, 1'b0);

    // Zero-length window goes straight to readout; en during drain is ignored.
    en = 4'b0000;
    push_expect(en, 0, 0);
    start_run(0, 0);
    check("zero_win_valid", rd_if.out_valid, 1);
    en = 4'b1111;
    drain(0, 1'b0);

    // Backpressure.
    en = 4'b0110;
    push_expect(en, 9, 1);
    start_run(9, 1);
    wait_window(9);
    drain(1, 1'b0);

    // Reset mid-count abandons the run.
    en = 4'b1111;
    start_run(16, 3);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", rd_if.out_valid, 0);
    check("midrst_chan", rd_if.out_chan, 0);
    check("midrst_data", rd_if.out_data, 0);
    check("midrst_over", rd_if.out_over, 0);
    check("midrst_last", rd_if.out_last, 0);
    check("midrst_done", done, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("postrst_no_done", done, 0);
      check("postrst_idle", busy, 0);
    end
    en = 4'b0100;
    push_expect(en, 8, 1);
    start_run(8, 1);
    wait_window(8);
    drain(0, 1'b0);

    // Extra start pulses during COUNT and DRAIN must not disturb the run.
    en = 4'b1010;
    push_expect(en, 10, 0);
    start_run(10, 0);
    tick();
    tick();
    start    = 1'b1;
    win_len  = WIN_W'(3);
    prescale = PRE_W'(5);
    tick();
    start    = 1'b0;
    repeat (10 - 1 - 3) tick();
    check("ignored_start_busy", busy, 1);
    check("ignored_start_no_valid", rd_if.out_valid, 0);
    tick();
    check("ignored_start_valid", rd_if.out_valid, 1);
    drain(0, 1'b1);
    tick();
    check("ignored_start_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_level_counter.md
Name: multi_level_counter

Overview:
- Parametrised successor to the single-channel readout-net level counter.
- Counts enabled events on CH independent channels over a programmable measurement window of clk cycles.
- Each channel has a programmable prescaler and a saturating WIDTH-bit level count.
- At window end, counts are frozen and streamed out one channel per valid/ready handshake to the readout network.

Parameters:
- CH, 4: number of event channels (>=1).
- WIDTH, 32: level-count width per channel.
- PRE_W, 6: prescaler width; terminal value is programmable.
- WIN_W, 16: measurement-window length width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle request to begin a measurement
- win_len  in  WIN_W  window length in cycles; sampled on start
- prescale  in  PRE_W  prescaler terminal value; sampled on start
- en  in  CH  per-channel event enable, sampled every COUNT cycle
- busy  out  1  high whenever state != IDLE
- out_valid  out  1  readout word valid
- out_ready  in  1  readout consumer ready
- out_chan  out  $clog2(CH) (min 1)  channel index of current word
- out_data  out  WIDTH  frozen level count of out_chan
- out_over  out  1  saturation flag of out_chan
- out_last  out  1  high with the word for channel CH-1
- done  out  1  single-cycle pulse after the last handshake

Behaviour:
- Reset (async assert, sync release): state=IDLE; all prescalers, counts and over flags = 0; window counter = 0; busy=0, out_valid=0, out_chan=0, out_data=0, out_over=0, out_last=0, done=0.
- FSM states: IDLE, COUNT, DRAIN.
- IDLE:
  - start=1 at edge k: latch win_len and prescale; clear all prescalers, counts and over flags.
  - If win_len != 0: go to COUNT with window counter = win_len.
  - If win_len == 0: go straight to DRAIN with all counts 0.
- COUNT:
  - en is sampled at edges k+1 .. k+win_len, i.e. exactly win_len cycles.
  - At each sampled edge, for every channel i with en[i]=1:
    - If prescaler_i == latched prescale: prescaler_i <= 0 and count_i increments.
    - Otherwise prescaler_i increments.
  - prescale=0: every enabled cycle increments the count.
  - Count increment saturates at 2^WIDTH-1. An increment attempted at saturation sets over_i, which stays sticky until the next start. No wrap.
  - Window counter decrements each edge. On the edge where it reaches 0, the last en sample is taken, counts freeze and state goes to DRAIN.
- DRAIN:
  - out_valid=1, out_chan starts at 0.
  - out_data and out_over show the frozen count and flag of out_chan. out_last = (out_chan == CH-1).
  - While out_valid=1 && out_ready=0, all outputs hold stable.
  - On handshake (valid && ready): out_chan increments.
  - On the handshake with out_last=1: out_valid drops next cycle, done=1 for exactly one cycle, state goes to IDLE, busy drops in the same cycle done rises.
  - Throughput: one word per cycle when out_ready is held high.
- start while not IDLE: ignored, with no effect on latched values or counts.
- en is ignored in IDLE and DRAIN.
- Counts persist in IDLE until the next start; they are not cleared at done.
- Reset mid-operation: immediate return to the reset state; a partial readout is abandoned, with no done pulse.
- Width rules:
  - Prescaler compare is an unsigned PRE_W-bit compare.
  - Window counter is WIN_W bits, so the maximum window is 2^WIN_W-1 cycles.
  - out_chan is max(1, $clog2(CH)) bits.

Decomposition:
- Package multi_level_counter_pkg holds:
  - state enum {IDLE, COUNT, DRAIN};
  - function/constant for the channel-index width, max(1, $clog2(CH)).
- One natural sub-module, level_counter_ch, instantiated CH times. It contains:
  - prescaler, saturating count and sticky over flag;
  - inputs: clk, rst_n, clr, cnt_en (= COUNT && en[i]), prescale;
  - outputs: count, over.
- The top holds the FSM, the window counter and the readout mux.

Test Plan:
- CH=4, prescale=3, win_len=16, en=4'b0001 constant, out_ready=1 -> words (0,4,0), (1,0,0), (2,0,0), (3,0,0) as (chan,data,over); out_last on chan 3; done pulse one cycle after that handshake.
- WIDTH=4, prescale=0, win_len=20, en=all ones -> every channel reads data=15, over=1. Same test with win_len=15 -> data=15, over=0.
- win_len=0, start -> DRAIN immediately (out_valid one cycle after start); 4 words all data=0; en activity during DRAIN has no effect.
- Backpressure: out_ready toggles 1,0,0,1,... -> out_chan/out_data/out_over/out_last stable while stalled; exactly CH handshakes; a single done pulse.
- rst_n low for 1 cycle mid-COUNT (cycle 7 of 16) -> all outputs 0, busy=0, no done. A following start with win_len=8, en[2]=1, prescale=1 -> channel 2 reads 4.
- start pulsed during COUNT and during DRAIN, with different win_len -> ignored; results and timing are identical to a run without the extra pulses.
